// File: rtl/cheri_tsmap_ctrl.sv
// cheri_tsmap_ctrl: revocation bitmap SRAM controller.
// Core lookups own the port, bus slave uses idle cycles.
module cheri_tsmap_ctrl #(
    parameter logic [31:0] TSMapBase = 32'h2002_f000,
    parameter int unsigned TSMapSize = 1024,
    parameter int unsigned RamAw     = $clog2(TSMapSize)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tsmap_cs_i,
    input  logic [15:0]      tsmap_addr_i,
    output logic [31:0]      tsmap_rdata_o,
    input  logic             bus_req_i,
    input  logic             bus_we_i,
    input  logic [3:0]       bus_be_i,
    input  logic [31:0]      bus_addr_i,
    input  logic [31:0]      bus_wdata_i,
    output logic             bus_gnt_o,
    output logic             bus_rvalid_o,
    output logic [31:0]      bus_rdata_o,
    output logic             bus_err_o,
    output logic             ram_req_o,
    output logic             ram_we_o,
    output logic [RamAw-1:0] ram_addr_o,
    output logic [31:0]      ram_wmask_o,
    output logic [31:0]      ram_wdata_o,
    input  logic [31:0]      ram_rdata_i,
    output logic             init_done_o
);

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    localparam logic [31:0]      SpanBytes = 32'(4 * TSMapSize);
    localparam logic [RamAw-1:0] LastIdx   = RamAw'(TSMapSize - 1);

    state_e           state_q, state_d;
    logic [RamAw-1:0] cnt_q, cnt_d;
    logic             core_vld_q;
    logic             rsp_vld_q, rsp_rd_q, rsp_err_q;

    logic        run;
    logic        core_in, core_rd;
    logic [31:0] bus_off;
    logic        bus_in, bus_acc;
    logic        gnt;

    assign run     = (state_q == RUN);
    assign core_in = ({16'd0, tsmap_addr_i} < TSMapSize);
    assign core_rd = run & tsmap_cs_i & core_in;

    // Offset wraps below the base; the lower-bound test rejects that.
    assign bus_off = bus_addr_i - TSMapBase;
    assign bus_in  = (bus_addr_i >= TSMapBase) && (bus_off < SpanBytes);
    assign gnt     = bus_req_i & run & (~bus_in | ~tsmap_cs_i);
    assign bus_acc = gnt & bus_in;

    // State and sweep counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep every word once, then hand the port over to traffic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIdx) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // SRAM port mux: sweep, then core lookup, then bus access.
    always_comb begin
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wmask_o = '0;
        ram_wdata_o = '0;
        if (!run) begin
            ram_req_o   = 1'b1;
            ram_we_o    = 1'b1;
            ram_addr_o  = cnt_q;
            ram_wmask_o = '1;
        end else if (core_rd) begin
            ram_req_o  = 1'b1;
            ram_addr_o = tsmap_addr_i[RamAw-1:0];
        end else if (bus_acc) begin
            ram_req_o  = 1'b1;
            ram_we_o   = bus_we_i;
            ram_addr_o = bus_off[RamAw+1:2];
            if (bus_we_i) begin
                ram_wmask_o = {{8{bus_be_i[3]}}, {8{bus_be_i[2]}},
                               {8{bus_be_i[1]}}, {8{bus_be_i[0]}}};
                ram_wdata_o = bus_wdata_i;
            end
        end
    end

    // Response tracking for the cycle after each access or grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            core_vld_q <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_rd_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            core_vld_q <= core_rd;
            rsp_vld_q  <= gnt;
            rsp_rd_q   <= bus_acc & ~bus_we_i;
            rsp_err_q  <= gnt & ~bus_in;
        end
    end

    assign bus_gnt_o     = gnt;
    assign bus_rvalid_o  = rsp_vld_q;
    assign bus_err_o     = rsp_err_q;
    assign bus_rdata_o   = rsp_rd_q ? ram_rdata_i : 32'd0;
    assign tsmap_rdata_o = core_vld_q ? ram_rdata_i : 32'd0;
    assign init_done_o   = run;

endmodule

// File: tb/tb_cheri_tsmap_ctrl.sv
// tb_cheri_tsmap_ctrl: random + directed bench with scoreboard.
// Holds a behavioural SRAM and a reference bitmap model.
module tb_cheri_tsmap_ctrl;

    localparam logic [31:0] BASE = 32'h2002_f000;
    localparam int unsigned SIZE = 16;
    localparam int unsigned AW   = $clog2(SIZE);

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          tsmap_cs = 1'b0;
    logic [15:0]   tsmap_addr = '0;
    logic [31:0]   tsmap_rdata;
    logic          bus_req = 1'b0;
    logic          bus_we = 1'b0;
    logic [3:0]    bus_be = '0;
    logic [31:0]   bus_addr = '0;
    logic [31:0]   bus_wdata = '0;
    logic          bus_gnt, bus_rvalid, bus_err;
    logic [31:0]   bus_rdata;
    logic          ram_req, ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wmask, ram_wdata;
    logic [31:0]   ram_rdata = '0;
    logic          init_done;

    cheri_tsmap_ctrl #(
        .TSMapBase(BASE),
        .TSMapSize(SIZE)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .tsmap_cs_i   (tsmap_cs),
        .tsmap_addr_i (tsmap_addr),
        .tsmap_rdata_o(tsmap_rdata),
        .bus_req_i    (bus_req),
        .bus_we_i     (bus_we),
        .bus_be_i     (bus_be),
        .bus_addr_i   (bus_addr),
        .bus_wdata_i  (bus_wdata),
        .bus_gnt_o    (bus_gnt),
        .bus_rvalid_o (bus_rvalid),
        .bus_rdata_o  (bus_rdata),
        .bus_err_o    (bus_err),
        .ram_req_o    (ram_req),
        .ram_we_o     (ram_we),
        .ram_addr_o   (ram_addr),
        .ram_wmask_o  (ram_wmask),
        .ram_wdata_o  (ram_wdata),
        .ram_rdata_i  (ram_rdata),
        .init_done_o  (init_done)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: starts with garbage, idle read data is random.
    logic [31:0] mem [SIZE];
    logic        seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < int'(SIZE); i++) mem[i] <= $urandom;
            seeded <= 1'b1;
        end else if (ram_req && ram_we) begin
            mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
        end
        if (ram_req && !ram_we) ram_rdata <= mem[ram_addr];
        else ram_rdata <= $urandom;
    end

    typedef struct {
        logic [31:0] core;
        logic        bv;
        logic        berr;
        logic [31:0] brd;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [SIZE];
    int          edges = 0;
    bit          mon_en = 1'b0;
    int          nchk = 0;
    int          nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per cycle, checked after the edge.
    always @(posedge clk) begin
        #1;
        if (mon_en && rst_ni) begin
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("tsmap_rdata", tsmap_rdata, e.core);
                chk("bus_rvalid", 32'(bus_rvalid), 32'(e.bv));
                if (e.bv) begin
                    chk("bus_err", 32'(bus_err), 32'(e.berr));
                    chk("bus_rdata", bus_rdata, e.brd);
                end
            end
        end
    end

    // One cycle of stimulus; entered and left at a negedge.
    task automatic step(input logic cs, input logic [15:0] ca, input logic req,
                        input logic we, input logic [3:0] be,
                        input logic [31:0] ba, input logic [31:0] wd);
        bit          run, core_rd, b_in, g, acc;
        longint      a;
        int          idx;
        logic [31:0] mask;
        exp_t        e;
        tsmap_cs = cs; tsmap_addr = ca;
        bus_req = req; bus_we = we; bus_be = be; bus_addr = ba; bus_wdata = wd;
        #1;
        run     = (edges >= int'(SIZE));
        core_rd = run && cs && (int'(ca) < int'(SIZE));
        a       = longint'(ba);
        b_in    = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * longint'(SIZE));
        idx     = b_in ? int'((a - longint'(BASE)) / 4) : 0;
        g       = req && run && (!b_in || !cs);
        acc     = g && b_in;
        mask    = '0;
        for (int b = 0; b < 4; b++) if (be[b]) mask[8*b +: 8] = 8'hFF;
        chk("bus_gnt", 32'(bus_gnt), 32'(g));
        chk("init_done", 32'(init_done), 32'(run));
        if (!run) begin
            chk("sweep_req", 32'(ram_req), 32'd1);
            chk("sweep_we", 32'(ram_we), 32'd1);
            chk("sweep_addr", 32'(ram_addr), 32'(edges));
            chk("sweep_mask", ram_wmask, 32'hFFFF_FFFF);
            chk("sweep_data", ram_wdata, 32'd0);
        end else begin
            chk("ram_req", 32'(ram_req), 32'(core_rd || acc));
            if (core_rd) begin
                chk("core_ram_we", 32'(ram_we), 32'd0);
                chk("core_ram_addr", 32'(ram_addr), 32'(ca));
            end else if (acc) begin
                chk("bus_ram_we", 32'(ram_we), 32'(we));
                chk("bus_ram_addr", 32'(ram_addr), 32'(idx));
                if (we) begin
                    chk("bus_ram_mask", ram_wmask, mask);
                    chk("bus_ram_wdata", ram_wdata, wd);
                end
            end else begin
                chk("idle_ram_addr", 32'(ram_addr), 32'd0);
            end
        end
        e.core = core_rd ? ref_mem[ca[AW-1:0]] : 32'd0;
        e.bv   = g;
        e.berr = g && !b_in;
        e.brd  = (acc && !we) ? ref_mem[idx] : 32'd0;
        if (acc && we) ref_mem[idx] = (ref_mem[idx] & ~mask) | (wd & mask);
        exp_q.push_back(e);
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 16'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    // Reset with idle inputs; release lands on a negedge.
    task automatic do_reset();
        mon_en = 1'b0;
        rst_ni = 1'b0;
        tsmap_cs = 1'b0; bus_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rvalid", 32'(bus_rvalid), 32'd0);
        chk("rst_gnt", 32'(bus_gnt), 32'd0);
        chk("rst_ram_req", 32'(ram_req), 32'd1);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_tsmap_rdata", tsmap_rdata, 32'd0);
        exp_q.delete();
        for (int i = 0; i < int'(SIZE); i++) ref_mem[i] = '0;
        edges = 0;
        rst_ni = 1'b1;
        mon_en = 1'b1;
    endtask

    function automatic logic [31:0] rnd_addr();
        unsigned_case: begin end
        case ($urandom_range(0, 5))
            0, 1, 2: return BASE + $urandom_range(0, 4 * SIZE - 1);
            3:       return BASE + 4 * SIZE + $urandom_range(0, 7);
            4:       return BASE - 1 - $urandom_range(0, 7);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        do_reset();
        // Sweep, with lookups and bus requests issued during INIT.
        for (int i = 0; i < int'(SIZE) + 2; i++)
            step(1'b1, 16'($urandom_range(0, SIZE - 1)), 1'b1, 1'b0, 4'hF,
                 BASE + 32'(4 * (i % SIZE)), 32'd0);
        // Bus write then core read of the same word.
        step(1'b0, 16'd0, 1'b1, 1'b1, 4'b0101, BASE + 32'd8, 32'hA5A5_A5A5);
        step(1'b1, 16'd2, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        idle();
        // Contention, then grant once the core backs off.
        repeat (3) step(1'b1, 16'd2, 1'b1, 1'b0, 4'hF, BASE + 32'd8, 32'd0);
        step(1'b0, 16'd0, 1'b1, 1'b0, 4'hF, BASE + 32'd8, 32'd0);
        // Out-of-range bus read alongside a core read.
        step(1'b1, 16'd2, 1'b1, 1'b0, 4'hF, BASE + 32'(4 * SIZE), 32'd0);
        // Out-of-range bus below base, out-of-range core lookup.
        step(1'b1, 16'(SIZE), 1'b1, 1'b1, 4'hF, BASE - 32'd4, 32'h1234_5678);
        step(1'b1, 16'hFFFF, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        idle();
        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) == 0, 16'($urandom_range(0, SIZE + 3)),
                 $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom),
                 rnd_addr(), $urandom);
        end
        idle();
        // Reset lands after a grant, before its response.
        tsmap_cs = 1'b0; bus_req = 1'b1; bus_we = 1'b0;
        bus_addr = BASE + 32'd4;
        #1;
        chk("midrst_gnt", 32'(bus_gnt), 32'd1);
        mon_en = 1'b0;
        rst_ni = 1'b0;
        bus_req = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_rvalid", 32'(bus_rvalid), 32'd0);
        end
        @(negedge clk);
        do_reset();
        for (int i = 0; i < int'(SIZE) + 2; i++) idle();
        for (int i = 0; i < 100; i++) begin
            step($urandom_range(0, 1) == 0, 16'($urandom_range(0, SIZE + 3)),
                 1'b1, 1'($urandom), 4'($urandom), rnd_addr(), $urandom);
        end
        idle();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
